// File: rtl/jt51_ring_sched.sv
// rtl/jt51_ring_sched.sv - slot scheduler and access arbiter for a 32-slot recirculating ring
//
// Owns the slot counter, clears the external ring after reset and drives the
// ring din. Queued writes are injected when their slot passes the ring port;
// single-slot reads are captured the same way.
//
// Optional feature macro: JT51_RING_RD_EN (read path present when defined;
// otherwise rd_ready/rd_done/rd_data are tied 0 and rd_valid/rd_slot ignored).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ring_out / ring_in  ring drop (data of slot_cnt) / ring din (combinational)
//   slot_cnt, sync      current slot at the port, high while slot_cnt==0
//   init_done           ring cleared, scheduler running
//   wr_valid/wr_ready   write handshake, wr_slot/wr_data payload, busy = queue non-empty
//   rd_valid/rd_ready   read handshake, rd_slot target, rd_data valid with rd_done pulse
module jt51_ring_sched #(
  parameter int WIDTH = 5,
  parameter int SLOTS = 32,
  parameter int DEPTH = 4,
  parameter int SW    = $clog2(SLOTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ring_out,
  output logic [WIDTH-1:0] ring_in,
  output logic [SW-1:0]    slot_cnt,
  output logic             sync,
  output logic             init_done,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [SW-1:0]    wr_slot,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [SW-1:0]    rd_slot,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t state, state_nx;
  logic   run;

  logic [SW-1:0]    fifo_slot [DEPTH];
  logic [WIDTH-1:0] fifo_data [DEPTH];
  logic [AW-1:0]    head, tail;
  logic [AW:0]      count;
  logic             full, push, inject;

  // Free-running slot counter; SLOTS is a power of two so it wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_cnt <= '0;
    else        slot_cnt <= slot_cnt + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nx;
  end

  // CLEAR lasts exactly one full revolution, starting at slot 0 after reset.
  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (slot_cnt == SW'(SLOTS - 1)) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = CLEAR;
    endcase
  end

  assign run       = (state == RUN);
  assign init_done = run;
  assign sync      = (slot_cnt == '0);

  // Write queue: only the head is ever compared against the ring port.
  assign full     = (count == (AW+1)'(DEPTH));
  assign busy     = (count != '0);
  assign wr_ready = run && !full;
  assign push     = wr_valid && wr_ready;
  assign inject   = run && busy && (fifo_slot[head] == slot_cnt);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_slot[tail] <= wr_slot;
      fifo_data[tail] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)   tail <= tail + AW'(1);
      if (inject) head <= head + AW'(1);
      case ({push, inject})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Unregistered ring_out -> ring_in path: zero fill, injection or recirculate.
  always_comb begin
    ring_in = '0;
    if (run) ring_in = inject ? fifo_data[head] : ring_out;
  end

`ifdef JT51_RING_RD_EN
  logic          rd_pend;
  logic [SW-1:0] rd_slot_q;

  assign rd_ready = run && !rd_pend;

  // ring_out is sampled before any same-cycle injection lands in the ring,
  // so a read colliding with a write returns the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend   <= 1'b0;
      rd_slot_q <= '0;
      rd_data   <= '0;
      rd_done   <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      if (rd_pend && slot_cnt == rd_slot_q) begin
        rd_data <= ring_out;
        rd_done <= 1'b1;
        rd_pend <= 1'b0;
      end else if (rd_valid && rd_ready) begin
        rd_pend   <= 1'b1;
        rd_slot_q <= rd_slot;
      end
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{rd_valid, rd_slot};
  assign rd_ready  = 1'b0;
  assign rd_done   = 1'b0;
  assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_jt51_ring_sched.sv
// tb/tb_jt51_ring_sched.sv - self-checking bench for jt51_ring_sched with an external ring model
module tb_jt51_ring_sched;

  localparam int WIDTH = 5;
  localparam int SLOTS = 32;
  localparam int DEPTH = 4;
  localparam int SW    = 5;
`ifdef JT51_RING_RD_EN
  localparam bit RD_EN = 1'b1;
`else
  localparam bit RD_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] ring_out, ring_in;
  logic [SW-1:0]    slot_cnt;
  logic             sync, init_done;
  logic             wr_valid, wr_ready;
  logic [SW-1:0]    wr_slot;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             rd_valid, rd_ready;
  logic [SW-1:0]    rd_slot;
  logic [WIDTH-1:0] rd_data;
  logic             rd_done;

  int n_checks = 0;
  int n_errors = 0;

  jt51_ring_sched #(.WIDTH(WIDTH), .SLOTS(SLOTS), .DEPTH(DEPTH), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .ring_out(ring_out), .ring_in(ring_in),
    .slot_cnt(slot_cnt), .sync(sync), .init_done(init_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_slot(wr_slot), .wr_data(wr_data),
    .busy(busy), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_slot(rd_slot),
    .rd_data(rd_data), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  // External ring: plain shift register; junk_fill stands in for unknown power-up contents.
  logic [WIDTH-1:0] sr [SLOTS];
  logic             junk_fill;
  assign ring_out = sr[SLOTS-1];
  always @(posedge clk) begin
    for (int i = SLOTS-1; i > 0; i--) sr[i] <= sr[i-1];
    sr[0] <= junk_fill ? WIDTH'($urandom) : ring_in;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: slot memory + write queue + one pending read, advanced once per cycle.
  typedef struct { logic [SW-1:0] s; logic [WIDTH-1:0] d; } wr_t;
  wr_t              q[$];
  logic [WIDTH-1:0] mem [SLOTS];
  int               cyc;
  bit               pend, m_done;
  logic [SW-1:0]    pslot;
  logic [WIDTH-1:0] m_rdata;
  logic [SW-1:0]    m_slot;
  bit               m_run, m_wrdy, m_rrdy, m_inj;
  logic [WIDTH-1:0] e_in;

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0; q.delete(); pend = 0; m_done = 0; m_rdata = '0;
      for (int i = 0; i < SLOTS; i++) mem[i] = '0;
      check("rst_slot_cnt", int'(slot_cnt), 0);
      check("rst_sync", int'(sync), 1);
      check("rst_init_done", int'(init_done), 0);
      check("rst_wr_ready", int'(wr_ready), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_rd_ready", int'(rd_ready), 0);
      check("rst_rd_data", int'(rd_data), 0);
      check("rst_rd_done", int'(rd_done), 0);
    end else begin
      m_slot = SW'(cyc % SLOTS);
      m_run  = (cyc >= SLOTS);
      m_wrdy = m_run && (q.size() < DEPTH);
      m_rrdy = RD_EN && m_run && !pend;
      m_inj  = m_run && (q.size() > 0) && (q[0].s == m_slot);
      e_in   = !m_run ? '0 : (m_inj ? q[0].d : mem[m_slot]);
      check("slot_cnt", int'(slot_cnt), int'(m_slot));
      check("sync", int'(sync), int'(m_slot == 0));
      check("init_done", int'(init_done), int'(m_run));
      check("wr_ready", int'(wr_ready), int'(m_wrdy));
      check("busy", int'(busy), int'(q.size() != 0));
      check("rd_ready", int'(rd_ready), int'(m_rrdy));
      check("rd_done", int'(rd_done), int'(m_done));
      check("rd_data", int'(rd_data), int'(m_rdata));
      check("ring_in", int'(ring_in), int'(e_in));
      if (m_run) check("ring_out", int'(ring_out), int'(mem[m_slot]));
      m_done = 0;
      if (pend && m_slot == pslot) begin
        m_rdata = mem[m_slot];
        m_done  = 1;
        pend    = 0;
      end
      if (rd_valid && m_rrdy) begin
        pend  = 1;
        pslot = rd_slot;
      end
      if (m_inj) begin
        mem[m_slot] = q[0].d;
        void'(q.pop_front());
      end
      if (wr_valid && m_wrdy) q.push_back(wr_t'{s: wr_slot, d: wr_data});
      cyc++;
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic wait_slot(input int s);
    int n = 0;
    while (int'(slot_cnt) != s && n < 2*SLOTS) begin step; n++; end
    if (int'(slot_cnt) != s) check("wait_slot_timeout", int'(slot_cnt), s);
  endtask

  task automatic do_write(input logic [SW-1:0] s, input logic [WIDTH-1:0] d);
    int n = 0;
    wr_slot = s; wr_data = d; wr_valid = 1'b1;
    @(negedge clk);
    while (!wr_ready && n < 100) begin @(negedge clk); n++; end
    if (!wr_ready) check("wr_timeout", int'(wr_ready), 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [SW-1:0] s);
    int n = 0;
    rd_slot = s; rd_valid = 1'b1;
    @(negedge clk);
    while (!rd_ready && n < 100) begin @(negedge clk); n++; end
    if (!rd_ready) check("rd_accept_timeout", int'(rd_ready), 1);
    @(posedge clk); #1;
    rd_valid = 1'b0;
  endtask

  task automatic wait_rd_done;
    int n = 0;
    while (!rd_done && n < 2*SLOTS+4) begin step; n++; end
    check("rd_done_timeout", int'(rd_done), 1);
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 4*SLOTS) begin step; n++; end
    check("busy_timeout", int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; junk_fill = 1'b1;
    wr_valid = 1'b0; wr_slot = '0; wr_data = '0;
    rd_valid = 1'b0; rd_slot = '0;
    repeat (40) @(posedge clk);
    #1;
    check("lit_rst_slot", int'(slot_cnt), 0);
    check("lit_rst_sync", int'(sync), 1);
    junk_fill = 1'b0;
    rst_n = 1'b1;

    // Clear pass: init_done rises exactly one revolution after release.
    repeat (31) step;
    check("lit_init_31", int'(init_done), 0);
    step;
    check("lit_init_32", int'(init_done), 1);
    check("lit_slot_32", int'(slot_cnt), 0);
    repeat (SLOTS) step;

    // Single write, injected at the target slot four cycles after slot 3.
    wait_slot(3);
    do_write(5'd7, 5'h15);
    wait_slot(7);
    check("lit_inject_7", int'(ring_in), 'h15);
    repeat (SLOTS) step;
    check("lit_pass_slot", int'(slot_cnt), 7);
    check("lit_ring_7", int'(ring_out), 'h15);

    // Burst beyond queue depth.
    wait_slot(10);
    do_write(5'd31, 5'h11);
    do_write(5'd0,  5'h12);
    do_write(5'd1,  5'h13);
    do_write(5'd2,  5'h14);
    check("lit_burst_full", int'(wr_ready), 0);
    check("lit_burst_busy", int'(busy), 1);
    do_write(5'd3, 5'h15);
    wait_idle;
    wait_slot(2);
    check("lit_ring_2", int'(ring_out), 'h14);
    repeat (SLOTS) step;

    if (RD_EN) begin
      wait_slot(20);
      do_write(5'd12, 5'h0A);
      wait_idle;
      do_read(5'd12);
      wait_rd_done;
      check("lit_rd_12", int'(rd_data), 'h0A);
      // Read and write to the same slot accepted together: old value returned.
      wait_slot(5);
      wr_slot = 5'd12; wr_data = 5'h1B; wr_valid = 1'b1;
      rd_slot = 5'd12; rd_valid = 1'b1;
      @(negedge clk);
      check("lit_both_wr_ready", int'(wr_ready), 1);
      check("lit_both_rd_ready", int'(rd_ready), 1);
      @(posedge clk); #1;
      wr_valid = 1'b0; rd_valid = 1'b0;
      wait_rd_done;
      check("lit_rd_collide", int'(rd_data), 'h0A);
      wait_slot(20);
      wait_slot(12);
      check("lit_ring_12", int'(ring_out), 'h1B);
    end else begin
      rd_valid = 1'b1; rd_slot = 5'd3;
      repeat (SLOTS + 8) step;
      check("lit_nord_ready", int'(rd_ready), 0);
      check("lit_nord_done", int'(rd_done), 0);
      rd_valid = 1'b0;
    end

    // Reset with writes queued and a read pending.
    wait_slot(5);
    do_write(5'd30, 5'h01);
    do_write(5'd29, 5'h02);
    do_write(5'd28, 5'h03);
    if (RD_EN) do_read(5'd27);
    check("lit_pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    repeat (3) step;
    check("lit_mid_rst_busy", int'(busy), 0);
    check("lit_mid_rst_init", int'(init_done), 0);
    rst_n = 1'b1;
    repeat (SLOTS) step;
    check("lit_reinit", int'(init_done), 1);
    wait_slot(7);
    check("lit_ring_7_cleared", int'(ring_out), 0);
    repeat (SLOTS + 4) step;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
